// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm match logic and the buzzer ringer.
// The master side drives the timing strobes and buttons; the slave drives the buzzer and indicators.
interface alarm_ringer_if;
    logic EN1HZ;
    logic SIG2HZ;
    logic MATCH;
    logic ARM;
    logic STOP;
    logic SNOOZE;
    logic BUZZ;
    logic RINGING;
    logic SNOOZING;

    modport master (
        output EN1HZ, SIG2HZ, MATCH, ARM, STOP, SNOOZE,
        input  BUZZ, RINGING, SNOOZING
    );

    modport slave (
        input  EN1HZ, SIG2HZ, MATCH, ARM, STOP, SNOOZE,
        output BUZZ, RINGING, SNOOZING
    );
endinterface

// File: rtl/alarm_ringer.sv
// Alarm ringer: rings the piezo buzzer when the alarm time matches.
// Supports timeout, stop, snooze with re-ring, and rings only once per matching minute.
module alarm_ringer #(
    parameter int TONE_DIV   = 12000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic           CLK,
    input  logic           RST,
    alarm_ringer_if.slave  bus
);

    localparam int DIV_W = (TONE_DIV > 2) ? $clog2(TONE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TONE_DIV - 1);
    localparam logic [9:0]       RING_LAST = 10'(RING_SEC - 1);
    localparam logic [9:0]       SNZ_LAST  = 10'(SNOOZE_SEC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNZ,
        DONE
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [9:0]       secCnt;
    logic [9:0]       nextSec;
    logic [DIV_W-1:0] divCnt;
    logic             toneReg;

    // DONE waits for MATCH to drop so the same matching minute cannot re-trigger.
    always_comb begin
        nextState = state;
        nextSec   = secCnt;
        case (state)
            IDLE: begin
                if (bus.ARM && bus.MATCH) begin
                    nextState = RING;
                end
            end
            RING: begin
                if (bus.STOP || !bus.ARM) begin
                    nextState = DONE;
                end else if (bus.SNOOZE) begin
                    nextState = SNZ;
                end else if (bus.EN1HZ) begin
                    if (secCnt == RING_LAST) begin
                        nextState = DONE;
                    end else begin
                        nextSec = secCnt + 10'd1;
                    end
                end
            end
            SNZ: begin
                if (bus.STOP || !bus.ARM) begin
                    nextState = DONE;
                end else if (bus.EN1HZ) begin
                    if (secCnt == SNZ_LAST) begin
                        nextState = RING;
                    end else begin
                        nextSec = secCnt + 10'd1;
                    end
                end
            end
            DONE: begin
                if (!bus.MATCH) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (nextState != state) begin
            nextSec = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            secCnt       <= '0;
            divCnt       <= '0;
            toneReg      <= 1'b0;
            bus.BUZZ     <= 1'b0;
            bus.RINGING  <= 1'b0;
            bus.SNOOZING <= 1'b0;
        end else begin
            state        <= nextState;
            secCnt       <= nextSec;
            bus.RINGING  <= (nextState == RING);
            bus.SNOOZING <= (nextState == SNZ);
            bus.BUZZ     <= toneReg && bus.SIG2HZ && (state == RING);
            // Tone generator restarts from a known phase on every entry into RING.
            if ((state == RING) && (nextState == RING)) begin
                if (divCnt == DIV_LAST) begin
                    divCnt  <= '0;
                    toneReg <= ~toneReg;
                end else begin
                    divCnt <= divCnt + 1'b1;
                end
            end else begin
                divCnt  <= '0;
                toneReg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alarm_ringer.sv
// Randomized scoreboard bench for alarm_ringer with a behavioural reference model.
// The model pushes expected outputs on every edge; a monitor pops and compares on the falling edge.
module tb_alarm_ringer;

    localparam int TONE_DIV   = 4;
    localparam int RING_SEC   = 3;
    localparam int SNOOZE_SEC = 2;

    localparam int M_IDLE = 0;
    localparam int M_RING = 1;
    localparam int M_SNZ  = 2;
    localparam int M_DONE = 3;

    logic CLK;
    logic RST;
    alarm_ringer_if bus();

    alarm_ringer #(
        .TONE_DIV   (TONE_DIV),
        .RING_SEC   (RING_SEC),
        .SNOOZE_SEC (SNOOZE_SEC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic curMatch = 1'b0;
    logic curArm   = 1'b0;
    logic curSig   = 1'b1;

    int mState = M_IDLE;
    int mSec = 0;
    int mRingCycles = 0;
    logic [2:0] expQ[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int n, input logic st, input logic sn);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cyc++;
            bus.EN1HZ  = (cyc % 20 == 0);
            bus.MATCH  = curMatch;
            bus.ARM    = curArm;
            bus.SIG2HZ = curSig;
            bus.STOP   = (i == 0) ? st : 1'b0;
            bus.SNOOZE = (i == 0) ? sn : 1'b0;
        end
    endtask

    // Reference model: counts strobes and ring cycles; tone phase follows from elapsed ring cycles.
    always @(posedge CLK) begin
        int ns;
        logic expBuzz;
        if (RST) begin
            mState = M_IDLE;
            mSec = 0;
            mRingCycles = 0;
            expQ.push_back(3'b000);
        end else begin
            expBuzz = (mState == M_RING) && (((mRingCycles / TONE_DIV) % 2) == 1) && bus.SIG2HZ;
            ns = mState;
            case (mState)
                M_IDLE: if (bus.ARM && bus.MATCH) ns = M_RING;
                M_RING: begin
                    if (bus.STOP || !bus.ARM) ns = M_DONE;
                    else if (bus.SNOOZE) ns = M_SNZ;
                    else if (bus.EN1HZ) begin
                        mSec++;
                        if (mSec == RING_SEC) ns = M_DONE;
                    end
                end
                M_SNZ: begin
                    if (bus.STOP || !bus.ARM) ns = M_DONE;
                    else if (bus.EN1HZ) begin
                        mSec++;
                        if (mSec == SNOOZE_SEC) ns = M_RING;
                    end
                end
                default: if (!bus.MATCH) ns = M_IDLE;
            endcase
            if (ns != mState) begin
                mSec = 0;
                mRingCycles = 0;
            end else if (ns == M_RING) begin
                mRingCycles++;
            end
            mState = ns;
            expQ.push_back({expBuzz, ns == M_RING, ns == M_SNZ});
        end
    end

    always @(negedge CLK) begin
        logic [2:0] exp;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard at %0t: got empty queue expected an entry", $time);
        end else begin
            exp = expQ.pop_front();
            checkOutput("BUZZ", bus.BUZZ, exp[2]);
            checkOutput("RINGING", bus.RINGING, exp[1]);
            checkOutput("SNOOZING", bus.SNOOZING, exp[0]);
        end
    end

    initial begin
        RST        = 1'b1;
        bus.EN1HZ  = 1'b0;
        bus.SIG2HZ = 1'b1;
        bus.MATCH  = 1'b0;
        bus.ARM    = 1'b0;
        bus.STOP   = 1'b0;
        bus.SNOOZE = 1'b0;
        #1;
        checkOutput("resetBUZZ", bus.BUZZ, 1'b0);
        checkOutput("resetRINGING", bus.RINGING, 1'b0);
        checkOutput("resetSNOOZING", bus.SNOOZING, 1'b0);
        applyStimulus(3, 1'b0, 1'b0);
        #2 RST = 1'b0;

        // Basic ring, auto-stop, no re-ring while MATCH holds, re-ring after MATCH drops.
        curArm = 1'b1;
        curMatch = 1'b1;
        applyStimulus(80, 1'b0, 1'b0);
        curMatch = 1'b0;
        applyStimulus(5, 1'b0, 1'b0);
        curMatch = 1'b1;
        applyStimulus(10, 1'b0, 1'b0);

        // STOP and SNOOZE together: STOP wins.
        applyStimulus(1, 1'b1, 1'b1);
        applyStimulus(10, 1'b0, 1'b0);
        curMatch = 1'b0;
        applyStimulus(3, 1'b0, 1'b0);
        curMatch = 1'b1;
        applyStimulus(8, 1'b0, 1'b0);

        // Snooze, re-ring, then auto-stop; extra SNOOZE while snoozing is ignored.
        applyStimulus(1, 1'b0, 1'b1);
        applyStimulus(7, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1);
        applyStimulus(130, 1'b0, 1'b0);
        curMatch = 1'b0;
        applyStimulus(3, 1'b0, 1'b0);

        // Disarm during snooze, then ARM=0 with MATCH=1 in IDLE.
        curMatch = 1'b1;
        applyStimulus(5, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 1'b1);
        applyStimulus(5, 1'b0, 1'b0);
        curArm = 1'b0;
        applyStimulus(5, 1'b0, 1'b0);
        curMatch = 1'b0;
        applyStimulus(3, 1'b0, 1'b0);
        curMatch = 1'b1;
        applyStimulus(10, 1'b0, 1'b0);

        // Cadence gate on SIG2HZ.
        curArm = 1'b1;
        applyStimulus(15, 1'b0, 1'b0);
        curSig = 1'b0;
        applyStimulus(15, 1'b0, 1'b0);
        curSig = 1'b1;
        applyStimulus(10, 1'b0, 1'b0);

        // Asynchronous reset mid-ring, released with MATCH and ARM high.
        curMatch = 1'b0;
        applyStimulus(70, 1'b0, 1'b0);
        curMatch = 1'b1;
        applyStimulus(10, 1'b0, 1'b0);
        #3 RST = 1'b1;
        #1;
        checkOutput("asyncRstBUZZ", bus.BUZZ, 1'b0);
        checkOutput("asyncRstRINGING", bus.RINGING, 1'b0);
        checkOutput("asyncRstSNOOZING", bus.SNOOZING, 1'b0);
        applyStimulus(2, 1'b0, 1'b0);
        #2 RST = 1'b0;
        applyStimulus(12, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            logic st;
            logic sn;
            if ($urandom_range(0, 39) == 0) curMatch = ~curMatch;
            if (curArm ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 19) == 0)) curArm = ~curArm;
            if ($urandom_range(0, 14) == 0) curSig = ~curSig;
            st = ($urandom_range(0, 119) == 0);
            sn = ($urandom_range(0, 49) == 0);
            applyStimulus(1, st, sn);
        end

        applyStimulus(2, 1'b0, 1'b0);
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ringer.md
Name: alarm_ringer

Overview:
- Downstream consumer of the clock/alarm-time comparator in CLOCK24: takes the time==alarm match level and the 1 Hz/2 Hz timing strobes and drives a piezo buzzer.
- Provides ring timeout, stop, snooze with re-ring, and a re-trigger guard so one matching minute rings only once.
- Sits between the top-level match logic and the buzzer/indicator pins.

Parameters:
- TONE_DIV, 12000, CLK cycles per tone half-period (48 MHz / 24000 = 2 kHz tone); legal range >= 2.
- RING_SEC, 60, seconds a ring lasts before auto-stop; legal range 1..1023.
- SNOOZE_SEC, 300, seconds spent in snooze before re-ring; legal range 1..1023.

Ports:
- CLK, in, 1, system clock.
- RST, in, 1, asynchronous active-high reset.
- EN1HZ, in, 1, one-CLK-wide pulse once per second.
- SIG2HZ, in, 1, 2 Hz square wave; gates the beep cadence.
- MATCH, in, 1, level; high while current time equals alarm time.
- ARM, in, 1, level; alarm enabled.
- STOP, in, 1, one-cycle debounced pulse.
- SNOOZE, in, 1, one-cycle debounced pulse.
- BUZZ, out, 1, buzzer drive.
- RINGING, out, 1, high in RING state.
- SNOOZING, out, 1, high in SNOOZE state.

Behaviour:
- Reset (async, RST=1): state=IDLE; sec counter=0; tone divider=0; tone reg=0; BUZZ=0, RINGING=0, SNOOZING=0.
  - Reset asserted mid-ring or mid-snooze aborts immediately to these values.
- All outputs are registered. RINGING and SNOOZING reflect the current state.
- States:
  - IDLE: if ARM & MATCH, go to RING and clear sec counter.
  - RING: sec counter increments on EN1HZ. Exits in priority order:
    1. STOP or ~ARM -> DONE.
    2. SNOOZE -> SNOOZE state; clear sec counter.
    3. sec counter == RING_SEC-1 with EN1HZ -> DONE (auto-stop after exactly RING_SEC strobes).
  - SNOOZE: sec counter increments on EN1HZ. Exits in priority order:
    1. STOP or ~ARM -> DONE.
    2. sec counter == SNOOZE_SEC-1 with EN1HZ -> RING; clear sec counter.
    - A SNOOZE pulse while in SNOOZE is ignored.
  - DONE: go to IDLE when MATCH=0. This prevents re-trigger in the same matching minute, and also after snooze if the minute still matches.
- Simultaneous events:
  - STOP and SNOOZE in the same cycle: STOP wins.
  - EN1HZ in the same cycle as a transition into RING/SNOOZE: not counted (counter loads 0).
  - EN1HZ on the terminal count together with STOP: STOP path taken, result identical (DONE).
- Sec counter: 10 bits, cleared on every state entry; never wraps, because it exits at the terminal count.
- Tone divider:
  - Counts 0..TONE_DIV-1 only in RING. At TONE_DIV-1 it returns to 0 and the tone reg toggles.
  - Outside RING, divider and tone reg are held at 0.
- BUZZ = registered (tone reg & SIG2HZ & RING). BUZZ is 0 in all other states, one cycle after leaving RING at the latest.
- Latency: MATCH&ARM rising -> RINGING=1 on the next CLK edge. First BUZZ high requires SIG2HZ=1 and TONE_DIV cycles of divider, plus one register.

Test Plan (TONE_DIV=4, RING_SEC=3, SNOOZE_SEC=2, EN1HZ every 20 cycles, SIG2HZ held 1 unless stated):
- Basic ring/auto-stop: ARM=1, raise MATCH -> RINGING=1 next cycle; BUZZ toggles every 4 cycles; after 3rd EN1HZ, RINGING=0, BUZZ=0. With MATCH still 1, no re-ring. Drop MATCH then raise it -> rings again.
- Stop: during RING, pulse STOP together with SNOOZE -> state DONE; SNOOZING never 1; BUZZ=0 within 1 cycle.
- Snooze cycle: during RING, pulse SNOOZE -> SNOOZING=1, BUZZ=0. After 2 EN1HZ -> RINGING=1 with counter at 0. Then 3 more EN1HZ -> DONE.
- Disarm: ARM=0 during SNOOZE -> DONE. ARM=0 with MATCH=1 in IDLE -> stays IDLE.
- Cadence gate: SIG2HZ=0 during RING -> BUZZ stays 0 while RINGING=1; SIG2HZ back to 1 -> tone resumes.
- Async reset: assert RST mid-RING between clock edges -> BUZZ, RINGING, SNOOZING go 0 without waiting for an edge. Release with MATCH=1 and ARM=1 -> RING re-entered on the first edge after release.
